pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Frame-synchronous controller between the HDMI timing/encoder core and a bank of pixel-pattern generators.
- Derives pixel coordinates from the encoder's read/line/frame strobes.
- Selects one of NUM_SRC pattern sources and presents its pixel as a registered output.
- Changes source only at frame boundaries: on manual next request, direct load, or automatic dwell timeout.

Parameters:
- NUM_SRC, 4: number of pattern sources, 2..2^SEL_W.
- SEL_W, 2: source-select width.
- DWELL_FRAMES, 300: frames per source in auto mode, >=1.
- DWELL_W, 9: dwell counter width; must hold DWELL_FRAMES-1.

Ports:
- i_pixclk  in  1  pixel clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rd  in  1  encoder requests a pixel this cycle (active video).
- i_newline  in  1  one-cycle strobe, start of line.
- i_newframe  in  1  one-cycle strobe, start of frame.
- i_next  in  1  one-cycle request: advance to next source.
- i_load  in  1  one-cycle request: jump to source i_load_sel.
- i_load_sel  in  SEL_W  target source for i_load.
- i_auto  in  1  level; 1 = auto-advance every DWELL_FRAMES frames.
- i_pix  in  NUM_SRC*24  source pixels; source k at [24k+23:24k], RGB 8:8:8 with R in the MSBs.
- o_hcount  out  12  pixel x coordinate.
- o_vcount  out  12  line y coordinate.
- o_sel  out  SEL_W  active source index.
- o_pix  out  24  registered selected pixel.
- o_locked  out  1  high once frame-aligned.
- o_switch  out  1  one-cycle pulse when o_sel changes.

Behaviour:
- Reset values: o_hcount=0, o_vcount=0, o_sel=0, o_pix=0, o_locked=0, o_switch=0, pending=0, dwell counter=0, state=INIT.
- Reset is synchronous; asserting it mid-frame forces all of the above on the next edge.
- FSM has two states.
  - INIT: counters held at 0, o_pix=0, requests ignored (not latched). On i_newframe -> RUN, and o_locked=1 from the next cycle.
  - RUN: normal operation. Leaves only on reset.
- Counters in RUN, modulo 4096.
  - o_hcount: 0 on i_newline or i_newframe; else +1 on i_rd.
  - o_vcount: 0 on i_newframe; else +1 on i_newline.
  - Priority is newframe > newline > rd. Same-cycle newline+rd gives hcount=0.
- Request latching in RUN.
  - i_load sets pending_load and captures i_load_sel; the last load in a frame wins.
  - i_next sets pending_next; multiple pulses in one frame collapse to one advance.
  - A request coinciding with i_newframe is applied at that same boundary.
- At i_newframe in RUN, one action is evaluated in priority order:
  1. Pending load: o_sel <= captured sel, clamped to NUM_SRC-1 if out of range.
  2. Pending next: o_sel <= (o_sel==NUM_SRC-1) ? 0 : o_sel+1.
  3. i_auto=1 and dwell==DWELL_FRAMES-1: advance as for next.
  4. Otherwise: no change.
  - Any change clears both pending flags and zeroes the dwell counter. Pending flags are always cleared at the boundary.
  - If no change: dwell increments when i_auto=1; dwell is held at 0 when i_auto=0.
- o_switch pulses for 1 cycle, on the cycle after the boundary edge, only if the new o_sel differs from the old (e.g. a load of the current index gives no pulse).
- Pixel path: o_pix <= i_pix[o_sel] every cycle in RUN.
  - Latency is 1 cycle from i_pix to o_pix.
  - o_sel is stable through each entire frame, so no mid-frame tearing.
  - o_pix=0 in INIT.

Test Plan:
- Reset, then 3 frames of 800 rd per line: no activity before first i_newframe, o_locked rises after it. At the 5th i_newline, o_vcount=5 and o_hcount=0.
- i_next pulsed 3 times mid-frame with sel=1, i_auto=0: o_sel stays 1 until i_newframe, then 2. Exactly one o_switch pulse.
- Same cycle as i_newframe: assert i_newline and i_rd with o_hcount=799: next cycle o_hcount=0, o_vcount=0.
- Set i_auto=1, DWELL_FRAMES=3, NUM_SRC=4: o_sel goes 0,1,2,3,0, changing every 3rd frame boundary. Wrap 3->0 produces o_switch.
- Same frame: i_load(sel=3) and i_next from sel=0 -> o_sel=3 at boundary. Then i_load_sel=2 with NUM_SRC=2 -> o_sel=1 (clamped).
- Drive source k pixel = 24'h0k0k0k with sel=2: o_pix=24'h020202 one cycle after i_pix is applied. Assert i_reset mid-line: next cycle o_pix=0, o_sel=0, o_locked=0.

Source files
------------

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame-synchronous source selector between the HDMI
// timing/encoder core and a bank of pixel-pattern generators. It tracks pixel
// coordinates from the encoder strobes, and switches the active pattern source
// only at frame boundaries, on a next request, a direct load or a dwell timeout.
module pattern_sequencer #(
   parameter int NUM_SRC      = 4,
   parameter int SEL_W        = 2,
   parameter int DWELL_FRAMES = 300,
   parameter int DWELL_W      = 9
) (
   input  logic                  i_pixclk,
   input  logic                  i_reset,
   input  logic                  i_rd,
   input  logic                  i_newline,
   input  logic                  i_newframe,
   input  logic                  i_next,
   input  logic                  i_load,
   input  logic [SEL_W-1:0]      i_load_sel,
   input  logic                  i_auto,
   input  logic [NUM_SRC*24-1:0] i_pix,
   output logic [11:0]           o_hcount,
   output logic [11:0]           o_vcount,
   output logic [SEL_W-1:0]      o_sel,
   output logic [23:0]           o_pix,
   output logic                  o_locked,
   output logic                  o_switch
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [SEL_W-1:0]   MAX_SEL    = SEL_W'(NUM_SRC - 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

   logic [0:0]         state;
   logic               pending_load;
   logic               pending_next;
   logic [SEL_W-1:0]   load_sel_q;
   logic [DWELL_W-1:0] dwell;

   logic               req_load;
   logic               req_next;
   logic [SEL_W-1:0]   req_sel;
   logic [SEL_W-1:0]   sel_inc;
   logic [SEL_W-1:0]   sel_clamped;
   logic [SEL_W-1:0]   new_sel;
   logic               do_change;
   logic [23:0]        pix_mux;

   // Frame alignment: wait in INIT for the first frame strobe, then run forever.
   always_ff @(posedge i_pixclk) begin
      // NOTE: every register in a clocked block uses <= so that all state
      // updates see the values from before the edge, regardless of order.
      if (i_reset) begin
         state    <= ST_INIT;
         o_locked <= 1'b0;
      end else if (state == ST_INIT && i_newframe) begin
         state    <= ST_RUN;
         o_locked <= 1'b1;
      end
   end

   // Pixel/line coordinates; frame strobe beats line strobe beats pixel read.
   always_ff @(posedge i_pixclk) begin
      if (i_reset || state == ST_INIT) begin
         o_hcount <= '0;
         o_vcount <= '0;
      end else if (i_newframe) begin
         o_hcount <= '0;
         o_vcount <= '0;
      end else if (i_newline) begin
         o_hcount <= '0;
         o_vcount <= o_vcount + 12'd1;
      end else if (i_rd) begin
         o_hcount <= o_hcount + 12'd1;
      end
   end

   // Boundary decision: requests arriving with the frame strobe count as
   // pending, so they take effect at this same boundary.
   always_comb begin
      // NOTE: each variable gets a default before any branch so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      req_load    = pending_load | i_load;
      req_next    = pending_next | i_next;
      req_sel     = i_load ? i_load_sel : load_sel_q;
      sel_inc     = (o_sel == MAX_SEL) ? '0 : o_sel + 1'b1;
      sel_clamped = (req_sel > MAX_SEL) ? MAX_SEL : req_sel;
      do_change   = 1'b1;
      new_sel     = o_sel;
      if (req_load) begin
         new_sel = sel_clamped;
      end else if (req_next) begin
         new_sel = sel_inc;
      end else if (i_auto && dwell == DWELL_LAST) begin
         new_sel = sel_inc;
      end else begin
         do_change = 1'b0;
      end
   end

   // Request latching during the frame and source switching at its boundary.
   always_ff @(posedge i_pixclk) begin
      if (i_reset) begin
         o_sel        <= '0;
         o_switch     <= 1'b0;
         pending_load <= 1'b0;
         pending_next <= 1'b0;
         load_sel_q   <= '0;
         dwell        <= '0;
      end else if (state == ST_RUN) begin
         o_switch <= 1'b0;
         if (i_newframe) begin
            o_sel        <= new_sel;
            o_switch     <= (new_sel != o_sel);
            pending_load <= 1'b0;
            pending_next <= 1'b0;
            if (do_change || !i_auto) begin
               dwell <= '0;
            end else begin
               dwell <= dwell + 1'b1;
            end
         end else begin
            if (i_load) begin
               pending_load <= 1'b1;
               load_sel_q   <= i_load_sel;
            end
            if (i_next) begin
               pending_next <= 1'b1;
            end
         end
      end
   end

   // Source multiplexer: picks the 24-bit slice of the active source.
   always_comb begin
      pix_mux = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (o_sel == SEL_W'(k)) begin
            pix_mux = i_pix[24*k +: 24];
         end
      end
   end

   // Registered pixel output; black until the stream is frame-aligned.
   always_ff @(posedge i_pixclk) begin
      if (i_reset || state == ST_INIT) begin
         o_pix <= '0;
      end else begin
         o_pix <= pix_mux;
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer. A 4-source instance with a short
// dwell is the main target; a 2-source instance shares the stimulus and is
// used to observe out-of-range load clamping.
`timescale 1ns/1ps
module tb_pattern_sequencer;

   logic        i_pixclk = 1'b0;
   logic        i_reset;
   logic        i_rd;
   logic        i_newline;
   logic        i_newframe;
   logic        i_next;
   logic        i_load;
   logic [1:0]  i_load_sel;
   logic        i_auto;
   logic [95:0] i_pix;

   logic [11:0] a_hcount, a_vcount, b_hcount, b_vcount;
   logic [1:0]  a_sel, b_sel;
   logic [23:0] a_pix, b_pix;
   logic        a_locked, a_switch, b_locked, b_switch;

   int n_checks = 0;
   int n_fail   = 0;
   int sw_count = 0;

   pattern_sequencer #(
      .NUM_SRC(4), .SEL_W(2), .DWELL_FRAMES(3), .DWELL_W(2)
   ) dut (
      .i_pixclk(i_pixclk), .i_reset(i_reset), .i_rd(i_rd),
      .i_newline(i_newline), .i_newframe(i_newframe), .i_next(i_next),
      .i_load(i_load), .i_load_sel(i_load_sel), .i_auto(i_auto),
      .i_pix(i_pix),
      .o_hcount(a_hcount), .o_vcount(a_vcount), .o_sel(a_sel),
      .o_pix(a_pix), .o_locked(a_locked), .o_switch(a_switch)
   );

   pattern_sequencer #(
      .NUM_SRC(2), .SEL_W(2), .DWELL_FRAMES(3), .DWELL_W(2)
   ) dut2 (
      .i_pixclk(i_pixclk), .i_reset(i_reset), .i_rd(i_rd),
      .i_newline(i_newline), .i_newframe(i_newframe), .i_next(i_next),
      .i_load(i_load), .i_load_sel(i_load_sel), .i_auto(i_auto),
      .i_pix(i_pix[47:0]),
      .o_hcount(b_hcount), .o_vcount(b_vcount), .o_sel(b_sel),
      .o_pix(b_pix), .o_locked(b_locked), .o_switch(b_switch)
   );

   always #5 i_pixclk = ~i_pixclk;

   // Advance one clock and sample 1 ns after the rising edge.
   task automatic cycle();
      @(posedge i_pixclk);
      #1;
      sw_count += int'(a_switch);
   endtask

   task automatic clear_inputs();
      i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0;
      i_next = 1'b0; i_load = 1'b0; i_load_sel = 2'd0;
   endtask

   task automatic pulse_newframe();
      i_newframe = 1'b1; cycle(); i_newframe = 1'b0;
   endtask

   task automatic pulse_newline();
      i_newline = 1'b1; cycle(); i_newline = 1'b0;
   endtask

   task automatic run_rd(input int n);
      i_rd = 1'b1;
      repeat (n) cycle();
      i_rd = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_auto = 1'b0; clear_inputs();
      i_pix = {4{24'hC3C3C3}};
      cycle(); cycle();
      i_reset = 1'b0;
      n_checks++; if (a_hcount !== 12'd0) begin n_fail++; $display("FAIL reset_hcount: got %0d expected 0", a_hcount); end
      n_checks++; if (a_vcount !== 12'd0) begin n_fail++; $display("FAIL reset_vcount: got %0d expected 0", a_vcount); end
      n_checks++; if (a_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", a_sel); end
      n_checks++; if (a_pix !== 24'h0) begin n_fail++; $display("FAIL reset_pix: got %h expected 000000", a_pix); end
      n_checks++; if (a_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", a_locked); end
      n_checks++; if (a_switch !== 1'b0) begin n_fail++; $display("FAIL reset_switch: got %b expected 0", a_switch); end
      // Activity before the first frame strobe must be ignored.
      pulse_newline();
      i_next = 1'b1; cycle(); i_next = 1'b0;
      i_load = 1'b1; i_load_sel = 2'd3; cycle(); i_load = 1'b0;
      run_rd(5);
      n_checks++; if (a_hcount !== 12'd0) begin n_fail++; $display("FAIL init_hcount: got %0d expected 0", a_hcount); end
      n_checks++; if (a_vcount !== 12'd0) begin n_fail++; $display("FAIL init_vcount: got %0d expected 0", a_vcount); end
      n_checks++; if (a_locked !== 1'b0) begin n_fail++; $display("FAIL init_locked: got %b expected 0", a_locked); end
      n_checks++; if (a_pix !== 24'h0) begin n_fail++; $display("FAIL init_pix: got %h expected 000000", a_pix); end
   endtask

   task automatic test_frames();
      for (int f = 0; f < 3; f++) begin
         pulse_newframe();
         n_checks++; if (a_locked !== 1'b1) begin n_fail++; $display("FAIL frame%0d_locked: got %b expected 1", f, a_locked); end
         n_checks++; if (a_hcount !== 12'd0) begin n_fail++; $display("FAIL frame%0d_hcount: got %0d expected 0", f, a_hcount); end
         n_checks++; if (a_vcount !== 12'd0) begin n_fail++; $display("FAIL frame%0d_vcount: got %0d expected 0", f, a_vcount); end
         n_checks++; if (a_sel !== 2'd0) begin n_fail++; $display("FAIL frame%0d_sel: got %0d expected 0", f, a_sel); end
         for (int l = 1; l <= 6; l++) begin
            pulse_newline();
            if (l == 5) begin
               n_checks++; if (a_vcount !== 12'd5) begin n_fail++; $display("FAIL line5_vcount: got %0d expected 5", a_vcount); end
               n_checks++; if (a_hcount !== 12'd0) begin n_fail++; $display("FAIL line5_hcount: got %0d expected 0", a_hcount); end
            end
            run_rd(800);
            if (l == 1) begin
               n_checks++; if (a_hcount !== 12'd800) begin n_fail++; $display("FAIL line_end_hcount: got %0d expected 800", a_hcount); end
            end
         end
      end
   endtask

   task automatic test_next();
      i_load = 1'b1; i_load_sel = 2'd1; cycle(); i_load = 1'b0;
      run_rd(3);
      pulse_newframe();
      n_checks++; if (a_sel !== 2'd1) begin n_fail++; $display("FAIL load1_sel: got %0d expected 1", a_sel); end
      n_checks++; if (a_switch !== 1'b1) begin n_fail++; $display("FAIL load1_switch: got %b expected 1", a_switch); end
      cycle();
      n_checks++; if (a_switch !== 1'b0) begin n_fail++; $display("FAIL switch_width: got %b expected 0", a_switch); end
      sw_count = 0;
      run_rd(4);
      for (int i = 0; i < 3; i++) begin
         i_next = 1'b1; cycle(); i_next = 1'b0;
         run_rd(2);
         n_checks++; if (a_sel !== 2'd1) begin n_fail++; $display("FAIL next_midframe%0d_sel: got %0d expected 1", i, a_sel); end
      end
      pulse_newframe();
      n_checks++; if (a_sel !== 2'd2) begin n_fail++; $display("FAIL next_boundary_sel: got %0d expected 2", a_sel); end
      n_checks++; if (a_switch !== 1'b1) begin n_fail++; $display("FAIL next_boundary_switch: got %b expected 1", a_switch); end
      cycle(); cycle();
      n_checks++; if (sw_count !== 1) begin n_fail++; $display("FAIL next_switch_count: got %0d expected 1", sw_count); end
   endtask

   task automatic test_boundary_priority();
      pulse_newline();
      run_rd(799);
      n_checks++; if (a_hcount !== 12'd799) begin n_fail++; $display("FAIL prio_pre_hcount: got %0d expected 799", a_hcount); end
      n_checks++; if (a_vcount !== 12'd1) begin n_fail++; $display("FAIL prio_pre_vcount: got %0d expected 1", a_vcount); end
      i_newframe = 1'b1; i_newline = 1'b1; i_rd = 1'b1;
      cycle();
      clear_inputs();
      n_checks++; if (a_hcount !== 12'd0) begin n_fail++; $display("FAIL prio_frame_hcount: got %0d expected 0", a_hcount); end
      n_checks++; if (a_vcount !== 12'd0) begin n_fail++; $display("FAIL prio_frame_vcount: got %0d expected 0", a_vcount); end
      n_checks++; if (a_sel !== 2'd2) begin n_fail++; $display("FAIL prio_frame_sel: got %0d expected 2", a_sel); end
      run_rd(5);
      i_newline = 1'b1; i_rd = 1'b1;
      cycle();
      clear_inputs();
      n_checks++; if (a_hcount !== 12'd0) begin n_fail++; $display("FAIL prio_line_hcount: got %0d expected 0", a_hcount); end
      n_checks++; if (a_vcount !== 12'd1) begin n_fail++; $display("FAIL prio_line_vcount: got %0d expected 1", a_vcount); end
   endtask

   task automatic test_auto();
      logic [1:0] exp_sel [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                   2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
      logic       exp_sw  [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      i_load = 1'b1; i_load_sel = 2'd0; cycle(); i_load = 1'b0;
      pulse_newframe();
      n_checks++; if (a_sel !== 2'd0) begin n_fail++; $display("FAIL auto_start_sel: got %0d expected 0", a_sel); end
      i_auto = 1'b1;
      for (int b = 0; b < 12; b++) begin
         pulse_newline();
         run_rd(4);
         pulse_newframe();
         n_checks++; if (a_sel !== exp_sel[b]) begin n_fail++; $display("FAIL auto_b%0d_sel: got %0d expected %0d", b + 1, a_sel, exp_sel[b]); end
         n_checks++; if (a_switch !== exp_sw[b]) begin n_fail++; $display("FAIL auto_b%0d_switch: got %b expected %b", b + 1, a_switch, exp_sw[b]); end
      end
      i_auto = 1'b0;
   endtask

   task automatic test_load_next();
      // Load 1, next, then load 3 in the same frame: the last load wins.
      run_rd(2);
      i_load = 1'b1; i_load_sel = 2'd1; cycle(); i_load = 1'b0;
      i_next = 1'b1; cycle(); i_next = 1'b0;
      i_load = 1'b1; i_load_sel = 2'd3; cycle(); i_load = 1'b0;
      run_rd(3);
      pulse_newframe();
      n_checks++; if (a_sel !== 2'd3) begin n_fail++; $display("FAIL load_next_sel: got %0d expected 3", a_sel); end
      n_checks++; if (a_switch !== 1'b1) begin n_fail++; $display("FAIL load_next_switch: got %b expected 1", a_switch); end
      n_checks++; if (b_sel !== 2'd1) begin n_fail++; $display("FAIL clamp3_sel: got %0d expected 1", b_sel); end
      // Load coincident with the frame strobe applies at that boundary.
      run_rd(3);
      i_newframe = 1'b1; i_load = 1'b1; i_load_sel = 2'd2;
      cycle();
      clear_inputs();
      n_checks++; if (a_sel !== 2'd2) begin n_fail++; $display("FAIL load_at_frame_sel: got %0d expected 2", a_sel); end
      n_checks++; if (b_sel !== 2'd1) begin n_fail++; $display("FAIL clamp2_sel: got %0d expected 1", b_sel); end
      n_checks++; if (b_switch !== 1'b0) begin n_fail++; $display("FAIL clamp2_switch: got %b expected 0", b_switch); end
   endtask

   task automatic test_pixel();
      i_pix = {24'h030303, 24'h020202, 24'h010101, 24'h000000};
      cycle();
      n_checks++; if (a_pix !== 24'h020202) begin n_fail++; $display("FAIL pix_sel2: got %h expected 020202", a_pix); end
      n_checks++; if (b_pix !== 24'h010101) begin n_fail++; $display("FAIL pix2_sel1: got %h expected 010101", b_pix); end
      i_pix[71:48] = 24'hA5A5A5;
      #2;
      n_checks++; if (a_pix !== 24'h020202) begin n_fail++; $display("FAIL pix_hold: got %h expected 020202", a_pix); end
      cycle();
      n_checks++; if (a_pix !== 24'hA5A5A5) begin n_fail++; $display("FAIL pix_latency: got %h expected a5a5a5", a_pix); end
      // Reset mid-line.
      pulse_newline();
      run_rd(10);
      i_rd = 1'b1; i_reset = 1'b1;
      cycle();
      i_reset = 1'b0;
      n_checks++; if (a_pix !== 24'h0) begin n_fail++; $display("FAIL rst_pix: got %h expected 000000", a_pix); end
      n_checks++; if (a_sel !== 2'd0) begin n_fail++; $display("FAIL rst_sel: got %0d expected 0", a_sel); end
      n_checks++; if (a_locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b expected 0", a_locked); end
      n_checks++; if (a_hcount !== 12'd0) begin n_fail++; $display("FAIL rst_hcount: got %0d expected 0", a_hcount); end
      n_checks++; if (a_vcount !== 12'd0) begin n_fail++; $display("FAIL rst_vcount: got %0d expected 0", a_vcount); end
      cycle();
      i_rd = 1'b0;
      n_checks++; if (a_pix !== 24'h0) begin n_fail++; $display("FAIL post_rst_pix: got %h expected 000000", a_pix); end
      n_checks++; if (a_hcount !== 12'd0) begin n_fail++; $display("FAIL post_rst_hcount: got %0d expected 0", a_hcount); end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_next();
      test_boundary_priority();
      test_auto();
      test_load_next();
      test_pixel();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
